// File: rtl/dispatch_lane_serializer.sv
// dispatch_lane_serializer
// Splits one full-warp dispatch packet into lane-width sub-packets for a
// functional unit narrower than the warp. Thread groups with an all-zero
// mask slice are skipped. The header is passed through unchanged.
// Data, mask and handshake outputs are combinational selects of the held
// input packet. Only the sequencing state (started flag, next pid) is
// registered.
module dispatch_lane_serializer #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int HDR_W       = 64,
    localparam int NUM_PKTS   = NUM_THREADS / NUM_LANES,
    localparam int PID_W      = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [HDR_W-1:0]            in_hdr,
    input  logic [NUM_THREADS-1:0]      in_tmask,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs3_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [HDR_W-1:0]            out_hdr,
    output logic [NUM_LANES-1:0]        out_tmask,
    output logic [NUM_LANES*XLEN-1:0]   out_rs1_data,
    output logic [NUM_LANES*XLEN-1:0]   out_rs2_data,
    output logic [NUM_LANES*XLEN-1:0]   out_rs3_data,
    output logic [PID_W-1:0]            out_pid,
    output logic                        out_sop,
    output logic                        out_eop,
    input  logic                        out_ready
);

    localparam int SLICE_W = NUM_LANES * XLEN;

    logic             r_started;
    logic [PID_W-1:0] r_pid;

    logic [NUM_PKTS-1:0] w_nonempty;
    logic [PID_W-1:0]    w_first;
    logic [PID_W-1:0]    w_cur_pid;
    logic [PID_W-1:0]    w_next;
    logic                w_has_next;
    logic                w_eop;
    logic                w_fire;
    int                  w_data_shift;
    int                  w_mask_shift;

    // Flag every thread group that has at least one active thread.
    always_comb begin
        w_nonempty = '0;
        for (int p = 0; p < NUM_PKTS; p++) begin
            w_nonempty[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
        end
    end

    // Lowest non-empty group; an empty mask falls back to group 0.
    always_comb begin
        w_first = '0;
        for (int p = NUM_PKTS - 1; p >= 0; p--) begin
            w_first = w_nonempty[p] ? PID_W'(p) : w_first;
        end
    end

    // Pick the current group and look ahead for the next non-empty one.
    always_comb begin
        w_cur_pid  = r_started ? r_pid : w_first;
        w_next     = '0;
        w_has_next = 1'b0;
        for (int p = NUM_PKTS - 1; p >= 0; p--) begin
            if (w_nonempty[p] && (p > int'(w_cur_pid))) begin
                w_next     = PID_W'(p);
                w_has_next = 1'b1;
            end else begin
                w_next     = w_next;
                w_has_next = w_has_next;
            end
        end
        w_eop        = ~w_has_next;
        w_fire       = in_valid & out_ready;
        w_data_shift = int'(w_cur_pid) * SLICE_W;
        w_mask_shift = int'(w_cur_pid) * NUM_LANES;
    end

    // Drive the sub-packet fields from the selected slice of the held input.
    always_comb begin
        out_valid    = in_valid;
        out_hdr      = in_hdr;
        out_tmask    = NUM_LANES'(in_tmask >> w_mask_shift);
        out_rs1_data = SLICE_W'(in_rs1_data >> w_data_shift);
        out_rs2_data = SLICE_W'(in_rs2_data >> w_data_shift);
        out_rs3_data = SLICE_W'(in_rs3_data >> w_data_shift);
        out_pid      = w_cur_pid;
        out_sop      = ~r_started;
        out_eop      = w_eop;
        in_ready     = out_ready & w_eop;
    end

    // Advance to the next non-empty group on each fire; rewind after the last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_started <= 1'b0;
            r_pid     <= '0;
        end else if (w_fire) begin
            if (w_eop) begin
                r_started <= 1'b0;
                r_pid     <= '0;
            end else begin
                r_started <= 1'b1;
                r_pid     <= w_next;
            end
        end else begin
            r_started <= r_started;
            r_pid     <= r_pid;
        end
    end

endmodule

// File: tb/tb_dispatch_lane_serializer.sv
// Bench for dispatch_lane_serializer: a 4-thread and an 8-thread instance
// (both 2 lanes) checked every cycle against a list-of-non-empty-groups model,
// plus directed literal expectations.
module tb_dispatch_lane_serializer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: 4 threads
    logic         a_vin, a_ordy, a_irdy, a_ov, a_osop, a_oeop;
    logic [63:0]  a_hdr, a_ohdr;
    logic [3:0]   a_tm;
    logic [127:0] a_r1, a_r2, a_r3;
    logic [1:0]   a_otm;
    logic [63:0]  a_o1, a_o2, a_o3;
    logic [0:0]   a_opid;

    // Instance B: 8 threads
    logic         b_vin, b_ordy, b_irdy, b_ov, b_osop, b_oeop;
    logic [63:0]  b_hdr, b_ohdr;
    logic [7:0]   b_tm;
    logic [255:0] b_r1, b_r2, b_r3;
    logic [1:0]   b_otm;
    logic [63:0]  b_o1, b_o2, b_o3;
    logic [1:0]   b_opid;

    dispatch_lane_serializer #(.NUM_THREADS(4), .NUM_LANES(2), .XLEN(32), .HDR_W(64)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_vin), .in_hdr(a_hdr), .in_tmask(a_tm),
        .in_rs1_data(a_r1), .in_rs2_data(a_r2), .in_rs3_data(a_r3), .in_ready(a_irdy),
        .out_valid(a_ov), .out_hdr(a_ohdr), .out_tmask(a_otm), .out_rs1_data(a_o1),
        .out_rs2_data(a_o2), .out_rs3_data(a_o3), .out_pid(a_opid), .out_sop(a_osop),
        .out_eop(a_oeop), .out_ready(a_ordy));

    dispatch_lane_serializer #(.NUM_THREADS(8), .NUM_LANES(2), .XLEN(32), .HDR_W(64)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_vin), .in_hdr(b_hdr), .in_tmask(b_tm),
        .in_rs1_data(b_r1), .in_rs2_data(b_r2), .in_rs3_data(b_r3), .in_ready(b_irdy),
        .out_valid(b_ov), .out_hdr(b_ohdr), .out_tmask(b_otm), .out_rs1_data(b_o1),
        .out_rs2_data(b_o2), .out_rs3_data(b_o3), .out_pid(b_opid), .out_sop(b_osop),
        .out_eop(b_oeop), .out_ready(b_ordy));

    int n_chk = 0;
    int n_err = 0;

    task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the ordered list of non-empty 2-thread groups of a mask
    function automatic int count_ne(input logic [7:0] tm, input int npk);
        int c = 0;
        for (int p = 0; p < npk; p++) if (tm[2*p +: 2] != 2'b00) c++;
        return c;
    endfunction

    function automatic int nth_ne(input logic [7:0] tm, input int npk, input int n);
        int c = 0;
        for (int p = 0; p < npk; p++) begin
            if (tm[2*p +: 2] != 2'b00) begin
                if (c == n) return p;
                c++;
            end
        end
        return 0;
    endfunction

    task automatic chk(input string nm, input int npk, input int idx, input logic vin, input logic ordy,
                       input logic [7:0] tm, input logic [255:0] r1, input logic [255:0] r2,
                       input logic [255:0] r3, input logic [63:0] hdr, input logic ov,
                       input logic [63:0] ohdr, input logic [1:0] otm, input logic [63:0] o1,
                       input logic [63:0] o2, input logic [63:0] o3, input logic [2:0] opid,
                       input logic osop, input logic oeop, input logic irdy,
                       output logic fire, output logic eop);
        int k, p;
        logic [255:0] s1, s2, s3;
        logic [7:0]   st;
        k   = count_ne(tm, npk);
        p   = (k == 0) ? 0 : nth_ne(tm, npk, idx);
        eop = (k == 0) || (idx >= k - 1);
        s1  = r1 >> (64 * p);
        s2  = r2 >> (64 * p);
        s3  = r3 >> (64 * p);
        st  = tm >> (2 * p);
        cmp({nm, ".valid"}, ov, vin);
        if (vin) begin
            cmp({nm, ".hdr"}, ohdr, hdr);
            cmp({nm, ".tmask"}, otm, st[1:0]);
            cmp({nm, ".rs1"}, o1, s1[63:0]);
            cmp({nm, ".rs2"}, o2, s2[63:0]);
            cmp({nm, ".rs3"}, o3, s3[63:0]);
            cmp({nm, ".pid"}, opid, p);
            cmp({nm, ".sop"}, osop, idx == 0);
            cmp({nm, ".eop"}, oeop, eop);
            cmp({nm, ".in_ready"}, irdy, ordy && eop);
        end
        fire = vin && ordy;
    endtask

    int   a_idx = 0, b_idx = 0;
    logic a_mf = 1'b0, a_me = 1'b0, b_mf = 1'b0, b_me = 1'b0;
    int   b_log[$];

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        chk("A", 2, a_idx, a_vin, a_ordy, {4'b0, a_tm}, {128'b0, a_r1}, {128'b0, a_r2},
            {128'b0, a_r3}, a_hdr, a_ov, a_ohdr, a_otm, a_o1, a_o2, a_o3, {2'b0, a_opid},
            a_osop, a_oeop, a_irdy, a_mf, a_me);
        chk("B", 4, b_idx, b_vin, b_ordy, b_tm, b_r1, b_r2, b_r3, b_hdr, b_ov, b_ohdr, b_otm,
            b_o1, b_o2, b_o3, {1'b0, b_opid}, b_osop, b_oeop, b_irdy, b_mf, b_me);
        if (b_ov && b_ordy) b_log.push_back(int'(b_opid));
    end

    // Model position within the current input's list of groups
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_idx <= 0;
            b_idx <= 0;
        end else begin
            if (a_mf) a_idx <= a_me ? 0 : a_idx + 1;
            if (b_mf) b_idx <= b_me ? 0 : b_idx + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [3:0] tm);
        a_vin = 1'b1;
        a_tm  = tm;
        a_hdr = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            a_r1[i*32 +: 32] = $urandom;
            a_r2[i*32 +: 32] = $urandom;
            a_r3[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic set_b(input logic [7:0] tm);
        b_vin = 1'b1;
        b_tm  = tm;
        b_hdr = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            b_r1[i*32 +: 32] = $urandom;
            b_r2[i*32 +: 32] = $urandom;
            b_r3[i*32 +: 32] = $urandom;
        end
    endtask

    // Literal beat check for instance A
    task automatic lit_a(input string nm, input int pid, input logic sop, input logic eop,
                         input logic [1:0] tm, input logic rdy);
        cmp({nm, ".valid"}, a_ov, 1'b1);
        cmp({nm, ".pid"}, a_opid, pid);
        cmp({nm, ".sop"}, a_osop, sop);
        cmp({nm, ".eop"}, a_oeop, eop);
        cmp({nm, ".tmask"}, a_otm, tm);
        cmp({nm, ".in_ready"}, a_irdy, rdy);
    endtask

    int tog_pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a_vin = 1'b0; a_tm = 4'b0; a_hdr = 64'b0; a_r1 = 128'b0; a_r2 = 128'b0; a_r3 = 128'b0;
        b_vin = 1'b0; b_tm = 8'b0; b_hdr = 64'b0; b_r1 = 256'b0; b_r2 = 256'b0; b_r3 = 256'b0;
        a_ordy = 1'b1; b_ordy = 1'b1;
        @(negedge clk);
        cmp("reset.valid", a_ov, 1'b0);
        cmp("reset.sop", a_osop, 1'b1);
        step(); step();
        reset = 1'b0;

        // Full mask: two beats
        set_a(4'b1111);
        @(negedge clk);
        lit_a("t1.c0", 0, 1'b1, 1'b0, 2'b11, 1'b0);
        cmp("t1.c0.rs1", a_o1, a_r1[63:0]);
        step();
        @(negedge clk);
        lit_a("t1.c1", 1, 1'b0, 1'b1, 2'b11, 1'b1);
        cmp("t1.c1.rs1", a_o1, a_r1[127:64]);
        step();
        // Single upper / lower group
        set_a(4'b1100);
        @(negedge clk);
        lit_a("t2.hi", 1, 1'b1, 1'b1, 2'b11, 1'b1);
        step();
        set_a(4'b0010);
        @(negedge clk);
        lit_a("t2.lo", 0, 1'b1, 1'b1, 2'b10, 1'b1);
        step();
        a_vin = 1'b0;

        // 8 threads, sparse mask: pids 0,1,3
        b_log.delete();
        set_b(8'b1000_0101);
        @(negedge clk);
        cmp("t3.c0.pid", b_opid, 2'd0);
        cmp("t3.c0.eop", b_oeop, 1'b0);
        step();
        @(negedge clk);
        cmp("t3.c1.pid", b_opid, 2'd1);
        cmp("t3.c1.eop", b_oeop, 1'b0);
        step();
        @(negedge clk);
        cmp("t3.c2.pid", b_opid, 2'd3);
        cmp("t3.c2.eop", b_oeop, 1'b1);
        cmp("t3.c2.sop", b_osop, 1'b0);
        step();
        b_vin = 1'b0;
        cmp("t3.beats", b_log.size(), 3);
        if (b_log.size() == 3) begin
            cmp("t3.log0", b_log[0], 0);
            cmp("t3.log1", b_log[1], 1);
            cmp("t3.log2", b_log[2], 3);
        end

        // Backpressure: held for 3 cycles, then both beats
        a_ordy = 1'b0;
        set_a(4'b1111);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lit_a("t4.hold", 0, 1'b1, 1'b0, 2'b11, 1'b0);
            step();
        end
        a_ordy = 1'b1;
        @(negedge clk);
        lit_a("t4.p0", 0, 1'b1, 1'b0, 2'b11, 1'b0);
        step();
        @(negedge clk);
        lit_a("t4.p1", 1, 1'b0, 1'b1, 2'b11, 1'b1);
        step();
        a_vin = 1'b0;

        // Toggling ready on an 8-thread full mask: pids 0..3 exactly once
        b_log.delete();
        set_b(8'hFF);
        for (int i = 0; i < 7; i++) begin
            b_ordy = (tog_pat[i] != 0);
            step();
        end
        b_vin = 1'b0;
        b_ordy = 1'b1;
        cmp("t5.beats", b_log.size(), 4);
        if (b_log.size() == 4) begin
            for (int i = 0; i < 4; i++) cmp("t5.log", b_log[i], i);
        end

        // Async reset mid-sequence restarts from pid0
        set_a(4'b1111);
        @(negedge clk);
        lit_a("t6.p0", 0, 1'b1, 1'b0, 2'b11, 1'b0);
        step();
        reset = 1'b1;
        @(negedge clk);
        lit_a("t6.inrst", 0, 1'b1, 1'b0, 2'b11, 1'b0);
        step();
        reset = 1'b0;
        @(negedge clk);
        lit_a("t6.restart", 0, 1'b1, 1'b0, 2'b11, 1'b0);
        step();
        @(negedge clk);
        lit_a("t6.p1", 1, 1'b0, 1'b1, 2'b11, 1'b1);
        step();

        // Empty mask: one beat, in_ready follows out_ready
        a_ordy = 1'b0;
        set_a(4'b0000);
        @(negedge clk);
        lit_a("t7.stall", 0, 1'b1, 1'b1, 2'b00, 1'b0);
        step();
        a_ordy = 1'b1;
        @(negedge clk);
        lit_a("t7.go", 0, 1'b1, 1'b1, 2'b00, 1'b1);
        step();

        // Back-to-back inputs without a bubble
        set_a(4'b1111);
        @(negedge clk);
        lit_a("t8.A0", 0, 1'b1, 1'b0, 2'b11, 1'b0);
        step();
        @(negedge clk);
        lit_a("t8.A1", 1, 1'b0, 1'b1, 2'b11, 1'b1);
        step();
        set_a(4'b0011);
        @(negedge clk);
        lit_a("t8.B0", 0, 1'b1, 1'b1, 2'b11, 1'b1);
        step();
        a_vin = 1'b0;

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
